// File: rtl/chroma_xform_seq.sv
// Phase sequencer for the chroma transform datapath: load, setup, per-block forward pass,
// then per-block output with bounded feedback wait, repeated per channel.
module chroma_xform_seq #(
    parameter int NBLK     = 4,
    parameter int NCH      = 2,
    parameter int IN_WORDS = 16,
    parameter int PRE_LEN  = 3,
    parameter int FWD_LEN  = 4,
    parameter int OUT_LEN  = 6,
    parameter int FB_TMO   = 255,
    parameter int CW       = 8,
    localparam int BW      = $clog2(NBLK) + 1,
    localparam int CHW     = $clog2(NCH) + 1
) (
    input  logic           CLK2,
    input  logic           NEWLINE,
    input  logic           STROBEI,
    input  logic           READYO,
    input  logic           FBSTROBE,
    input  logic           fbpending,
    output logic           ph_load,
    output logic           ph_pre,
    output logic           ph_fwd,
    output logic           ph_out,
    output logic           ph_fb,
    output logic [CW-1:0]  step,
    output logic [BW-1:0]  blk,
    output logic [CHW-1:0] ch,
    output logic           ch_done,
    output logic           mb_done,
    output logic           fb_err,
    output logic           drop_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_FWD, S_WAIT, S_OUT, S_FB, S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] tmo;
    logic          fb_busy;

    assign fb_busy = fbpending | FBSTROBE;

    always_ff @(posedge CLK2) begin
        if (NEWLINE) begin
            state    <= S_IDLE;
            step     <= '0;
            blk      <= '0;
            ch       <= '0;
            wcnt     <= '0;
            tmo      <= '0;
            fb_err   <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            if (STROBEI && state != S_IDLE)
                drop_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (STROBEI) begin
                        if (wcnt == CW'(IN_WORDS - 1)) begin
                            wcnt  <= '0;
                            step  <= '0;
                            state <= S_PRE;
                        end else begin
                            wcnt <= wcnt + CW'(1);
                        end
                    end
                end
                S_PRE: begin
                    if (step == CW'(PRE_LEN - 1)) begin
                        step  <= '0;
                        blk   <= '0;
                        state <= S_FWD;
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                S_FWD: begin
                    if (step == CW'(FWD_LEN - 1)) begin
                        step <= '0;
                        if (blk < BW'(NBLK - 1)) begin
                            blk <= blk + BW'(1);
                        end else begin
                            blk   <= '0;
                            state <= S_WAIT;
                        end
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (READYO) begin
                        step  <= '0;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (step == CW'(OUT_LEN - 1)) begin
                        step  <= '0;
                        tmo   <= '0;
                        state <= S_FB;
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                S_FB: begin
                    if (fb_busy && tmo < CW'(FB_TMO)) begin
                        tmo <= tmo + CW'(1);
                    end else begin
                        // Still busy here means the wait was cut short by the timeout.
                        if (fb_busy)
                            fb_err <= 1'b1;
                        if (blk < BW'(NBLK - 1)) begin
                            blk   <= blk + BW'(1);
                            state <= S_WAIT;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    ch    <= (ch == CHW'(NCH - 1)) ? '0 : ch + CHW'(1);
                    blk   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    step  <= '0;
                    blk   <= '0;
                    ch    <= '0;
                    wcnt  <= '0;
                    tmo   <= '0;
                end
            endcase
        end
    end

    assign ph_load = (state == S_IDLE);
    assign ph_pre  = (state == S_PRE);
    assign ph_fwd  = (state == S_FWD);
    assign ph_out  = (state == S_OUT);
    assign ph_fb   = (state == S_FB);
    assign ch_done = (state == S_DONE);
    assign mb_done = (state == S_DONE) && (ch == CHW'(NCH - 1));

endmodule

// File: tb/tb_chroma_xform_seq.sv
// Directed bench for chroma_xform_seq: default, short-timeout and minimal-size instances
// share stimulus; the ones not under test are held in reset.
module tb_chroma_xform_seq;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic strobe, readyo, fbstrobe, fbpend;

    logic       a_load, a_pre, a_fwd, a_out, a_fb, a_chd, a_mbd, a_fberr, a_drop;
    logic [7:0] a_step;
    logic [2:0] a_blk;
    logic [1:0] a_ch;
    logic       b_load, b_pre, b_fwd, b_out, b_fb, b_chd, b_mbd, b_fberr, b_drop;
    logic [7:0] b_step;
    logic [2:0] b_blk;
    logic [1:0] b_ch;
    logic       c_load, c_pre, c_fwd, c_out, c_fb, c_chd, c_mbd, c_fberr, c_drop;
    logic [7:0] c_step;
    logic [0:0] c_blk;
    logic [0:0] c_ch;

    logic [4:0] a_ph, b_ph, c_ph;
    assign a_ph = {a_load, a_pre, a_fwd, a_out, a_fb};
    assign b_ph = {b_load, b_pre, b_fwd, b_out, b_fb};
    assign c_ph = {c_load, c_pre, c_fwd, c_out, c_fb};

    localparam logic [4:0] P_LOAD = 5'b10000;
    localparam logic [4:0] P_PRE  = 5'b01000;
    localparam logic [4:0] P_FWD  = 5'b00100;
    localparam logic [4:0] P_OUT  = 5'b00010;
    localparam logic [4:0] P_FB   = 5'b00001;
    localparam logic [4:0] P_NONE = 5'b00000;

    chroma_xform_seq dut_a (
        .CLK2(clk), .NEWLINE(rst_a), .STROBEI(strobe), .READYO(readyo),
        .FBSTROBE(fbstrobe), .fbpending(fbpend),
        .ph_load(a_load), .ph_pre(a_pre), .ph_fwd(a_fwd), .ph_out(a_out), .ph_fb(a_fb),
        .step(a_step), .blk(a_blk), .ch(a_ch), .ch_done(a_chd), .mb_done(a_mbd),
        .fb_err(a_fberr), .drop_err(a_drop)
    );

    chroma_xform_seq #(.FB_TMO(8)) dut_b (
        .CLK2(clk), .NEWLINE(rst_b), .STROBEI(strobe), .READYO(readyo),
        .FBSTROBE(fbstrobe), .fbpending(fbpend),
        .ph_load(b_load), .ph_pre(b_pre), .ph_fwd(b_fwd), .ph_out(b_out), .ph_fb(b_fb),
        .step(b_step), .blk(b_blk), .ch(b_ch), .ch_done(b_chd), .mb_done(b_mbd),
        .fb_err(b_fberr), .drop_err(b_drop)
    );

    chroma_xform_seq #(.NBLK(1), .NCH(1), .IN_WORDS(1), .PRE_LEN(1), .FWD_LEN(1),
                       .OUT_LEN(1)) dut_c (
        .CLK2(clk), .NEWLINE(rst_c), .STROBEI(strobe), .READYO(readyo),
        .FBSTROBE(fbstrobe), .fbpending(fbpend),
        .ph_load(c_load), .ph_pre(c_pre), .ph_fwd(c_fwd), .ph_out(c_out), .ph_fb(c_fb),
        .step(c_step), .blk(c_blk), .ch(c_ch), .ch_done(c_chd), .mb_done(c_mbd),
        .fb_err(c_fberr), .drop_err(c_drop)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_words(input int n);
        strobe = 1'b1;
        repeat (n) tick();
        strobe = 1'b0;
    endtask

    // Nominal pass of instance A; entered at cycle 1 (first PRE cycle).
    task automatic run_nominal(input int pass);
        logic [4:0] eph;
        int estep, eblk, ech, echd, emb, r;
        for (int c = 1; c <= 53; c++) begin
            estep = 0; eblk = 0; ech = pass; echd = 0; emb = 0;
            if (c <= 3) begin
                eph = P_PRE; estep = c - 1;
            end else if (c <= 19) begin
                eph = P_FWD; estep = (c - 4) % 4; eblk = (c - 4) / 4;
            end else if (c <= 51) begin
                r = (c - 20) % 8; eblk = (c - 20) / 8;
                if (r == 0) eph = P_NONE;
                else if (r <= 6) begin eph = P_OUT; estep = r - 1; end
                else eph = P_FB;
            end else if (c == 52) begin
                eph = P_NONE; eblk = 3; echd = 1; emb = (pass == 1) ? 1 : 0;
            end else begin
                eph = P_LOAD; ech = (pass + 1) % 2;
            end
            chk($sformatf("nom%0d_ph_c%0d", pass, c), a_ph, eph);
            chk($sformatf("nom%0d_step_c%0d", pass, c), a_step, estep);
            chk($sformatf("nom%0d_blk_c%0d", pass, c), a_blk, eblk);
            chk($sformatf("nom%0d_ch_c%0d", pass, c), a_ch, ech);
            chk($sformatf("nom%0d_done_c%0d", pass, c), {a_chd, a_mbd}, {echd[0], emb[0]});
            if (c < 53) tick();
        end
    endtask

    initial begin
        int n;
        logic [4:0] cph;
        strobe = 0; readyo = 1; fbstrobe = 0; fbpend = 0;
        rst_a = 1; rst_b = 1; rst_c = 1;

        // T1 reset
        tick(); tick();
        chk("rst_ph", a_ph, P_LOAD);
        chk("rst_step", a_step, 0);
        chk("rst_blk", a_blk, 0);
        chk("rst_ch", a_ch, 0);
        chk("rst_flags", {a_chd, a_mbd, a_fberr, a_drop}, 0);
        chk("rst_c_ph", c_ph, P_LOAD);
        chk("rst_c_flags", {c_chd, c_mbd, c_fberr, c_drop, c_blk, c_ch}, 0);

        // T2 nominal passes, ch 0 then 1 (mb_done, wrap)
        rst_a = 0;
        tick();
        load_words(16);
        run_nominal(0);
        load_words(16);
        run_nominal(1);

        // T3 backpressure at first WAIT
        readyo = 0;
        load_words(16);
        repeat (19) tick();
        repeat (10) begin
            chk("bp_ph", a_ph, P_NONE);
            chk("bp_chd", a_chd, 0);
            chk("bp_step", a_step, 0);
            chk("bp_blk", a_blk, 0);
            tick();
        end
        readyo = 1;
        chk("bp_still_wait", a_ph, P_NONE);
        tick();
        chk("bp_out_ph", a_ph, P_OUT);
        chk("bp_out_step", a_step, 0);
        chk("bp_out_blk", a_blk, 0);

        // T4 feedback wait after block 1 output
        repeat (5) tick();
        tick(); chk("fb0_ph", a_ph, P_FB);
        tick(); chk("fb0_wait_blk", a_blk, 1);
        tick(); chk("b1_out_ph", a_ph, P_OUT);
        repeat (5) tick();
        chk("b1_out_step", a_step, 5);
        tick();
        chk("fb1_enter", a_ph, P_FB);
        fbpend = 1;
        repeat (5) begin
            chk("fb1_hold_ph", a_ph, P_FB);
            chk("fb1_hold_blk", a_blk, 1);
            tick();
        end
        fbpend = 0;
        chk("fb1_last_ph", a_ph, P_FB);
        tick();
        chk("fb1_exit_ph", a_ph, P_NONE);
        chk("fb1_exit_chd", a_chd, 0);
        chk("fb1_exit_blk", a_blk, 2);
        chk("fb1_no_err", a_fberr, 0);
        n = 0;
        while (a_chd !== 1'b1 && n < 100) begin tick(); n++; end
        chk("p2_done_seen", a_chd, 1);
        chk("p2_mbd", a_mbd, 0);
        tick();
        chk("p2_ch", a_ch, 1);

        // T6 drop during FWD, wcnt unaffected
        load_words(16);
        repeat (3) tick();
        chk("drop_pre_fwd", a_ph, P_FWD);
        chk("drop_pre_err", a_drop, 0);
        strobe = 1; tick(); strobe = 0;
        chk("drop_err", a_drop, 1);
        chk("drop_fwd_step", a_step, 1);
        n = 0;
        while (a_chd !== 1'b1 && n < 100) begin tick(); n++; end
        chk("p3_done_seen", a_chd, 1);
        chk("p3_mbd", a_mbd, 1);
        tick();
        chk("p3_ch_wrap", a_ch, 0);
        load_words(15);
        chk("wcnt_15_idle", a_ph, P_LOAD);
        load_words(1);
        chk("wcnt_16_pre", a_ph, P_PRE);
        chk("drop_sticky", a_drop, 1);
        n = 0;
        while (a_chd !== 1'b1 && n < 100) begin tick(); n++; end
        chk("p4_done_seen", a_chd, 1);
        tick();

        // T6 reset mid-OUT with non-zero ch/blk/step
        load_words(16);
        n = 0;
        while (!(a_out === 1'b1 && a_blk == 2 && a_step == 3) && n < 100) begin tick(); n++; end
        chk("mid_out_seen", {a_out, a_blk, a_ch}, {1'b1, 3'd2, 2'd1});
        rst_a = 1; tick(); rst_a = 0;
        chk("mid_rst_ph", a_ph, P_LOAD);
        chk("mid_rst_cnt", {a_step, a_blk, a_ch}, 0);
        chk("mid_rst_err", {a_fberr, a_drop, a_chd, a_mbd}, 0);
        rst_a = 1;

        // T5 timeout on instance B (FB_TMO=8)
        rst_b = 0;
        fbpend = 1;
        tick();
        load_words(16);
        n = 0;
        while (b_fb !== 1'b1 && n < 100) begin tick(); n++; end
        chk("tmo_fb_seen", b_fb, 1);
        chk("tmo_err_before", b_fberr, 0);
        n = 0;
        while (b_fb === 1'b1 && n < 50) begin tick(); n++; end
        chk("tmo_fb_cycles", n, 9);
        chk("tmo_err_set", b_fberr, 1);
        chk("tmo_exit_ph", {b_ph, b_chd}, 6'b0);
        chk("tmo_exit_blk", b_blk, 1);
        n = 0;
        while (b_chd !== 1'b1 && n < 200) begin tick(); n++; end
        chk("tmo_done_seen", b_chd, 1);
        tick();
        chk("tmo_idle", b_ph, P_LOAD);
        chk("tmo_ch", b_ch, 1);
        chk("tmo_err_sticky", b_fberr, 1);
        fbpend = 0;
        rst_b = 1; tick();
        chk("tmo_err_cleared", b_fberr, 0);

        // Minimal configuration: DONE 6 cycles after the last word
        rst_c = 0;
        tick();
        load_words(1);
        for (int c = 1; c <= 7; c++) begin
            case (c)
                1: cph = P_PRE;
                2: cph = P_FWD;
                4: cph = P_OUT;
                5: cph = P_FB;
                7: cph = P_LOAD;
                default: cph = P_NONE;
            endcase
            chk($sformatf("min_ph_c%0d", c), c_ph, cph);
            chk($sformatf("min_done_c%0d", c), {c_chd, c_mbd}, (c == 6) ? 2'b11 : 2'b00);
            chk($sformatf("min_idx_c%0d", c), {c_step, c_blk, c_ch}, 0);
            if (c < 7) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
